// File: rtl/controle_exibicao_sequencia.sv
// controle_exibicao_sequencia: plays back the stored color sequence on the LEDs, one color per on/off slot.
// Optional ACELERA_EN: dificuldade=1 at start halves the on-time of every color.
module controle_exibicao_sequencia #(
    parameter int ADDR_W    = 4,
    parameter int DATA_W    = 4,
    parameter int ON_TICKS  = 500,
    parameter int OFF_TICKS = 250
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              iniciar,
    input  logic              cancela,
    input  logic [ADDR_W-1:0] limite,
    input  logic              dificuldade,
    input  logic [DATA_W-1:0] mem_dado,
    output logic [ADDR_W-1:0] mem_endereco,
    output logic [DATA_W-1:0] leds,
    output logic              ocupado,
    output logic              pronto,
    output logic [2:0]        db_estado
);
    localparam int MAXT = ON_TICKS > OFF_TICKS ? ON_TICKS : OFF_TICKS;
    localparam int CW   = $clog2(MAXT + 1);

    typedef enum logic [2:0] {
        OCIOSO   = 3'd0,
        ENDERECA = 3'd1,
        LE       = 3'd2,
        ACESO    = 3'd3,
        APAGADO  = 3'd4,
        FIM      = 3'd5
    } estado_t;

    estado_t           estado_q, estado_d;
    logic [ADDR_W-1:0] addr_q, addr_d, lim_q, lim_d;
    logic [DATA_W-1:0] cor_q, cor_d, leds_q, leds_d;
    logic [CW-1:0]     cnt_q, cnt_d, t_on_fim;
    logic              pronto_q, pronto_d, ocupado_q, ocupado_d;

`ifdef ACELERA_EN
    logic dif_q, dif_d;
    always_comb dif_d = (estado_q == OCIOSO && iniciar && !cancela) ? dificuldade : dif_q;
    always_ff @(posedge clock or negedge reset)
        if (!reset) dif_q <= 1'b0;
        else        dif_q <= dif_d;
    assign t_on_fim = dif_q ? CW'((ON_TICKS >> 1) - 1) : CW'(ON_TICKS - 1);
`else
    logic unused_dificuldade;
    assign unused_dificuldade = dificuldade;
    assign t_on_fim = CW'(ON_TICKS - 1);
`endif

    always_comb begin
        estado_d = estado_q;
        addr_d   = addr_q;
        lim_d    = lim_q;
        cor_d    = cor_q;
        cnt_d    = cnt_q;
        case (estado_q)
            OCIOSO: if (iniciar) begin
                lim_d    = limite;
                addr_d   = '0;
                estado_d = ENDERECA;
            end
            ENDERECA: estado_d = LE;
            LE: begin
                cor_d    = mem_dado;
                cnt_d    = '0;
                estado_d = ACESO;
            end
            ACESO: if (cnt_q == t_on_fim) begin
                cnt_d    = '0;
                estado_d = APAGADO;
            end else cnt_d = cnt_q + 1'b1;
            // terminal compare precedes the increment, so addr never wraps
            APAGADO: if (cnt_q == CW'(OFF_TICKS - 1)) begin
                cnt_d = '0;
                if (addr_q == lim_q) estado_d = FIM;
                else begin
                    addr_d   = addr_q + 1'b1;
                    estado_d = ENDERECA;
                end
            end else cnt_d = cnt_q + 1'b1;
            FIM:     estado_d = OCIOSO;
            default: estado_d = OCIOSO;
        endcase
        if (cancela) begin
            estado_d = OCIOSO;
            addr_d   = '0;
            cnt_d    = '0;
        end
        leds_d    = estado_d == ACESO ? cor_d : '0;
        pronto_d  = estado_d == FIM;
        ocupado_d = estado_d != OCIOSO;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q  <= OCIOSO;
            addr_q    <= '0;
            lim_q     <= '0;
            cor_q     <= '0;
            cnt_q     <= '0;
            leds_q    <= '0;
            pronto_q  <= 1'b0;
            ocupado_q <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            addr_q    <= addr_d;
            lim_q     <= lim_d;
            cor_q     <= cor_d;
            cnt_q     <= cnt_d;
            leds_q    <= leds_d;
            pronto_q  <= pronto_d;
            ocupado_q <= ocupado_d;
        end
    end

    assign mem_endereco = addr_q;
    assign leds         = leds_q;
    assign pronto       = pronto_q;
    assign ocupado      = ocupado_q;
    assign db_estado    = estado_q;
endmodule

// File: tb/tb_controle_exibicao_sequencia.sv
// tb_controle_exibicao_sequencia: randomized playback checks against a slot-arithmetic model of the display timing.
`timescale 1ns/1ps
module tb_controle_exibicao_sequencia;
    localparam int AW = 4, DW = 4, ON = 4, OFF = 2;

    logic          clock = 1'b0, reset = 1'b0, iniciar = 1'b0, cancela = 1'b0, dificuldade = 1'b0;
    logic [AW-1:0] limite = '0, mem_endereco;
    logic [DW-1:0] mem_dado = '0, leds;
    logic          ocupado, pronto;
    logic [2:0]    db_estado;
    logic [DW-1:0] mem [16];
    int            errors = 0, checks = 0;

    always #5 clock = ~clock;
    always @(posedge clock) mem_dado <= mem[mem_endereco];

    controle_exibicao_sequencia #(.ADDR_W(AW), .DATA_W(DW), .ON_TICKS(ON), .OFF_TICKS(OFF)) dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .cancela(cancela), .limite(limite),
        .dificuldade(dificuldade), .mem_dado(mem_dado), .mem_endereco(mem_endereco), .leds(leds),
        .ocupado(ocupado), .pronto(pronto), .db_estado(db_estado)
    );

    function automatic int t_on(input logic d);
`ifdef ACELERA_EN
        return d ? ON / 2 : ON;
`else
        return ON;
`endif
    endfunction

    // cycle k after the cycle in which iniciar was high: {leds, pronto, ocupado, mem_endereco}
    function automatic logic [9:0] expect_at(input int k, input int lim, input int t);
        int p = 2 + t + OFF;
        int e, o;
        logic [DW-1:0] l;
        if (k == (lim + 1) * p + 1) return {4'b0, 1'b1, 1'b1, AW'(lim)};
        if (k > (lim + 1) * p + 1) return {4'b0, 1'b0, 1'b0, AW'(lim)};
        e = (k - 1) / p;
        o = (k - 1) % p;
        l = (o >= 2 && o < 2 + t) ? mem[e] : '0;
        return {l, 1'b0, 1'b1, AW'(e)};
    endfunction

    task automatic fill_pattern();
        for (int a = 0; a < 16; a++) mem[a] = DW'(1 << (a % 4));
    endtask

    task automatic fill_random();
        for (int a = 0; a < 16; a++) mem[a] = DW'($urandom);
    endtask

    task automatic play(input int lim, input logic d, input int glitch);
        int t = t_on(d);
        int n = (lim + 1) * (2 + t + OFF) + 2;
        logic [9:0] got, exp;
        @(posedge clock); #1 limite = AW'(lim); dificuldade = d; iniciar = 1'b1;
        @(posedge clock); #1 iniciar = 1'b0; limite = AW'($urandom); dificuldade = 1'($urandom);
        for (int k = 1; k <= n; k++) begin
            @(negedge clock);
            got = {leds, pronto, ocupado, mem_endereco};
            exp = expect_at(k, lim, t);
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL play lim=%0d dif=%0d k=%0d got=%h exp=%h", lim, d, k, got, exp);
            end
            if (k == n) begin
                checks++;
                if (db_estado !== 3'd0) begin
                    errors++;
                    $display("FAIL play_idle_state lim=%0d got=%0d exp=0", lim, db_estado);
                end
            end
            @(posedge clock); #1 iniciar = (k + 1 == glitch); limite = AW'($urandom);
        end
        iniciar = 1'b0;
    endtask

    task automatic test_reset();
        logic seen;
        fill_pattern();
        reset = 1'b0;
        #2;
        checks++;
        if ({leds, pronto, ocupado, mem_endereco, db_estado} !== '0) begin
            errors++;
            $display("FAIL reset_state got=%h exp=0", {leds, pronto, ocupado, mem_endereco, db_estado});
        end
        @(negedge clock) reset = 1'b1;
        @(posedge clock); #1 limite = 4'd2; iniciar = 1'b1;
        @(posedge clock); #1 iniciar = 1'b0;
        repeat (3) @(negedge clock);
        checks++;
        if (leds !== mem[0]) begin
            errors++;
            $display("FAIL reset_pre_aceso got=%h exp=%h", leds, mem[0]);
        end
        #1 reset = 1'b0;
        #1;
        checks++;
        if ({leds, db_estado, ocupado} !== '0) begin
            errors++;
            $display("FAIL reset_async got=%h exp=0", {leds, db_estado, ocupado});
        end
        @(negedge clock) reset = 1'b1;
        seen = 1'b0;
        repeat (30) begin
            @(negedge clock);
            seen |= pronto | ocupado;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_pronto got=%b exp=0", seen);
        end
    endtask

    task automatic test_cancel();
        logic seen;
        fill_pattern();
        @(posedge clock); #1 limite = 4'd3; iniciar = 1'b1;
        @(posedge clock); #1 iniciar = 1'b0;
        repeat (12) @(negedge clock);
        checks++;
        if (leds !== mem[1]) begin
            errors++;
            $display("FAIL cancel_second_lit got=%h exp=%h", leds, mem[1]);
        end
        #1 cancela = 1'b1;
        @(negedge clock);
        checks++;
        if ({leds, pronto, ocupado, mem_endereco, db_estado} !== '0) begin
            errors++;
            $display("FAIL cancel_idle got=%h exp=0", {leds, pronto, ocupado, mem_endereco, db_estado});
        end
        #1 cancela = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clock);
            seen |= pronto | ocupado;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL cancel_no_pronto got=%b exp=0", seen);
        end
    endtask

    task automatic test_cancel_wins();
        logic seen = 1'b0;
        @(negedge clock); #1 iniciar = 1'b1; cancela = 1'b1;
        @(negedge clock); #1 iniciar = 1'b0; cancela = 1'b0;
        repeat (5) begin
            @(negedge clock);
            seen |= ocupado | (db_estado != 3'd0);
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL cancel_wins got=%b exp=0", seen);
        end
    endtask

    task automatic test_random();
        repeat (4) begin
            fill_random();
            play(int'($urandom_range(0, 5)), 1'($urandom), int'($urandom_range(3, 6)));
        end
    endtask

    initial begin
        test_reset();
        fill_pattern();
        play(0, 1'b0, 0);
        play(2, 1'b0, 0);
        play(2, 1'b0, 4);
        fill_random();
        play(15, 1'b0, 0);
        test_cancel();
        test_cancel_wins();
        fill_pattern();
        play(1, 1'b1, 0);
        play(1, 1'b0, 0);
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
